// File: rtl/soc_system_cpu_s0_oci_trace_fifo.sv
// rtl/soc_system_cpu_s0_oci_trace_fifo.sv - OCI trace capture FIFO with capture/drain/done end-of-test sequencing
// Optional stored-parity checking is enabled by defining OCI_TRACE_PARITY_EN.
module soc_system_cpu_s0_oci_trace_fifo #(
    parameter int DATA_W    = 30,
    parameter int DEPTH     = 16,
    parameter int WRAP_MODE = 0,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dct_wr,
    input  logic [DATA_W-1:0] dct_buffer,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  dct_count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
`ifdef OCI_TRACE_PARITY_EN
    output logic              rd_parity,
    output logic              parity_err,
`endif
    input  logic              test_ending,
    output logic              test_has_ended
);

    localparam int PTR_W = CNT_W - 1;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, empty_q;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    logic push_ok, pop_ok, wr_en;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_CAPTURE: if (test_ending) state_d = ST_DRAIN;
            ST_DRAIN:   if (count_q == '0) state_d = ST_DONE;
            ST_DONE:    state_d = ST_DONE;
            default:    state_d = ST_CAPTURE;
        endcase
    end

    // Only CAPTURE accepts pushes; pops are gated purely by occupancy.
    assign push_ok = dct_wr && (state_q == ST_CAPTURE);
    assign pop_ok  = rd_req && !empty_q;

    always_comb begin
        wr_en      = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok && pop_ok) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else if (push_ok && !full_q) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = count_q + CNT_W'(1);
        end else if (push_ok) begin
            overflow_d = 1'b1;
            if (WRAP_MODE != 0) begin
                // Overwrite the oldest entry: write and read pointers move together.
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end else if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= dct_buffer;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CAPTURE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == CNT_W'(DEPTH));
            empty_q    <= (count_d == '0);
            overflow_q <= overflow_d;
            rd_valid_q <= pop_ok;
            if (pop_ok) begin
                rd_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

`ifdef OCI_TRACE_PARITY_EN
    logic par_mem_q [DEPTH];
    logic rd_parity_q;
    logic parity_err_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            par_mem_q[wr_ptr_q] <= ^dct_buffer;
        end
    end

    // Check is made on the registered word, so it covers the RAM read path too.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_parity_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (pop_ok) begin
                rd_parity_q <= par_mem_q[rd_ptr_q];
            end
            if (rd_valid_q && ((^rd_data_q) != rd_parity_q)) begin
                parity_err_q <= 1'b1;
            end
        end
    end

    assign rd_parity  = rd_parity_q;
    assign parity_err = parity_err_q;
`endif

    assign rd_data        = rd_data_q;
    assign rd_valid       = rd_valid_q;
    assign dct_count      = count_q;
    assign full           = full_q;
    assign empty          = empty_q;
    assign overflow       = overflow_q;
    assign test_has_ended = (state_q == ST_DONE);

endmodule

// File: tb/tb_soc_system_cpu_s0_oci_trace_fifo.sv
// tb/tb_soc_system_cpu_s0_oci_trace_fifo.sv - directed bench for the OCI trace FIFO, drop and wrap instances
module tb_soc_system_cpu_s0_oci_trace_fifo;

    localparam int DATA_W = 30;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              dct_wr;
    logic [DATA_W-1:0] dct_buffer;
    logic              rd_req;
    logic              test_ending;

    logic [DATA_W-1:0] rd_data,   w_rd_data;
    logic              rd_valid,  w_rd_valid;
    logic [CNT_W-1:0]  dct_count, w_dct_count;
    logic              full,      w_full;
    logic              empty,     w_empty;
    logic              overflow,  w_overflow;
    logic              test_has_ended, w_test_has_ended;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    soc_system_cpu_s0_oci_trace_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WRAP_MODE(0)) u_dut (
        .clk(clk), .reset(reset), .dct_wr(dct_wr), .dct_buffer(dct_buffer), .rd_req(rd_req),
        .rd_data(rd_data), .rd_valid(rd_valid), .dct_count(dct_count), .full(full), .empty(empty),
        .overflow(overflow), .test_ending(test_ending), .test_has_ended(test_has_ended)
    );

    soc_system_cpu_s0_oci_trace_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WRAP_MODE(1)) u_dut_wrap (
        .clk(clk), .reset(reset), .dct_wr(dct_wr), .dct_buffer(dct_buffer), .rd_req(rd_req),
        .rd_data(w_rd_data), .rd_valid(w_rd_valid), .dct_count(w_dct_count), .full(w_full), .empty(w_empty),
        .overflow(w_overflow), .test_ending(test_ending), .test_has_ended(w_test_has_ended)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        check("rst_rd_data",   32'(rd_data), 32'h0);
        check("rst_rd_valid",  32'(rd_valid), 32'h0);
        check("rst_count",     32'(dct_count), 32'h0);
        check("rst_full",      32'(full), 32'h0);
        check("rst_empty",     32'(empty), 32'h1);
        check("rst_overflow",  32'(overflow), 32'h0);
        check("rst_has_ended", 32'(test_has_ended), 32'h0);
    endtask

    initial begin
        reset = 1'b1; dct_wr = 1'b0; dct_buffer = '0; rd_req = 1'b0; test_ending = 1'b0;
        #1;
        step();
        step();
        reset = 1'b0;
        check_reset_state();

        // Fill 1..16
        for (int i = 1; i <= 16; i++) begin
            dct_wr = 1'b1;
            dct_buffer = DATA_W'(i);
            step();
            check("fill_count", 32'(dct_count), 32'(i));
            check("fill_full",  32'(full), (i == 16) ? 32'h1 : 32'h0);
            check("fill_empty", 32'(empty), 32'h0);
        end

        // Push and pop together while full
        dct_buffer = DATA_W'(17);
        rd_req = 1'b1;
        step();
        check("pp_full_valid", 32'(rd_valid), 32'h1);
        check("pp_full_data",  32'(rd_data), 32'h1);
        check("pp_full_count", 32'(dct_count), 32'd16);
        check("pp_full_ovf",   32'(overflow), 32'h0);

        // Drain all 16, back to back: 2..16 then 17
        dct_wr = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            check("pop_valid", 32'(rd_valid), 32'h1);
            check("pop_data",  32'(rd_data), 32'(k + 1));
            check("pop_count", 32'(dct_count), 32'(16 - k));
            check("pop_full",  32'(full), 32'h0);
        end
        check("drained_empty", 32'(empty), 32'h1);
        check("drained_ovf",   32'(overflow), 32'h0);

        // Pop on empty is ignored
        step();
        check("pop_empty_valid", 32'(rd_valid), 32'h0);
        check("pop_empty_count", 32'(dct_count), 32'h0);

        // Push and pop together while empty
        dct_wr = 1'b1;
        dct_buffer = DATA_W'(32'h55);
        step();
        check("pp_empty_valid", 32'(rd_valid), 32'h0);
        check("pp_empty_count", 32'(dct_count), 32'h1);
        dct_wr = 1'b0;
        step();
        check("pp_empty_pop_valid", 32'(rd_valid), 32'h1);
        check("pp_empty_pop_data",  32'(rd_data), 32'h55);
        check("pp_empty_pop_count", 32'(dct_count), 32'h0);
        rd_req = 1'b0;

        // Push 20: drop instance keeps 1..16, wrap instance keeps 5..20
        for (int i = 1; i <= 20; i++) begin
            dct_wr = 1'b1;
            dct_buffer = DATA_W'(i);
            step();
        end
        dct_wr = 1'b0;
        check("drop_count", 32'(dct_count), 32'd16);
        check("drop_ovf",   32'(overflow), 32'h1);
        check("wrap_count", 32'(w_dct_count), 32'd16);
        check("wrap_ovf",   32'(w_overflow), 32'h1);
        check("wrap_full",  32'(w_full), 32'h1);
        rd_req = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check("drop_pop_data", 32'(rd_data), 32'(k));
            check("wrap_pop_data", 32'(w_rd_data), 32'(k + 4));
        end
        rd_req = 1'b0;
        step();
        check("drop_end_empty", 32'(empty), 32'h1);
        check("wrap_end_empty", 32'(w_empty), 32'h1);
        check("drop_ovf_sticky", 32'(overflow), 32'h1);

        // End of test
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("eot_rst_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 3; i++) begin
            dct_wr = 1'b1;
            dct_buffer = DATA_W'(32'hA1 + i);
            step();
        end
        dct_wr = 1'b0;
        test_ending = 1'b1;
        step();
        check("eot_count3", 32'(dct_count), 32'd3);
        test_ending = 1'b0;
        dct_wr = 1'b1;
        dct_buffer = DATA_W'(32'hBB);
        rd_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("eot_pop_data",  32'(rd_data), 32'(32'hA1 + k));
            check("eot_pop_count", 32'(dct_count), 32'(2 - k));
            check("eot_not_ended", 32'(test_has_ended), 32'h0);
        end
        rd_req = 1'b0;
        step();
        check("eot_ended",       32'(test_has_ended), 32'h1);
        check("eot_push_ignored", 32'(dct_count), 32'h0);
        check("eot_no_ovf",      32'(overflow), 32'h0);
        rd_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("done_held",     32'(test_has_ended), 32'h1);
            check("done_no_valid", 32'(rd_valid), 32'h0);
            check("done_count",    32'(dct_count), 32'h0);
        end
        dct_wr = 1'b0;
        rd_req = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_state();

        // Reset while a read is requested: no rd_valid
        dct_wr = 1'b1;
        dct_buffer = DATA_W'(32'h3C);
        step();
        dct_wr = 1'b0;
        rd_req = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd_req = 1'b0;
        check("rst_inflight_valid", 32'(rd_valid), 32'h0);
        check("rst_inflight_count", 32'(dct_count), 32'h0);
        check("rst_inflight_empty", 32'(empty), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
